lfsr_gen: RTL and testbench

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen.sv | 98 +++++++++
 tb/tb_lfsr_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR pattern generator with ready/valid output,
// all-zero lockup detection, and a wrap pulse when the sequence returns to its seed.
module lfsr_gen #(
   parameter int NBITS = 16,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [127:0]     data,
   input  logic             load,
   input  logic [NBITS-1:0] taps,
   input  logic             mode,
   input  logic             en,
   input  logic             ready,
   output logic [NBITS-1:0] q,
   output logic             valid,
   output logic             lockup,
   output logic             wrap,
   output logic [CNT_W-1:0] count
);

   if (NBITS < 2 || NBITS > 128) begin : g_bad_nbits
      $error("lfsr_gen: NBITS must be in 2..128");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOCK = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [NBITS-1:0] seed_r, taps_r;
   logic             mode_r;
   logic [NBITS-1:0] seed_in;
   logic [NBITS-1:0] fib_nxt, gal_nxt, q_step;
   logic             step, hit;

   assign seed_in = data[NBITS-1:0];

   // Upper seed bits are intentionally ignored.
   if (NBITS < 128) begin : g_unused_data
      logic unused_data;
      assign unused_data = ^data[127:NBITS];
   end

   assign fib_nxt = {q[NBITS-2:0], ^(q & taps_r)};
   assign gal_nxt = (q >> 1) ^ (q[0] ? taps_r : '0);
   assign q_step  = mode_r ? gal_nxt : fib_nxt;
   assign step    = (state == RUN) && en && ready;
   assign hit     = (q_step == seed_r);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load) begin
         state_nxt = (seed_in == '0) ? LOCK : RUN;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (step && q_step == '0) state_nxt = LOCK;
            LOCK:    state_nxt = LOCK;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      valid  = (state == RUN);
      lockup = (state == LOCK);
   end

   // Load wins over a step; in IDLE/LOCK q simply holds its zero value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q      <= '0;
         seed_r <= '0;
         taps_r <= '0;
         mode_r <= 1'b0;
         count  <= '0;
         wrap   <= 1'b0;
      end else if (load) begin
         q      <= seed_in;
         seed_r <= seed_in;
         taps_r <= taps;
         mode_r <= mode;
         count  <= '0;
         wrap   <= 1'b0;
      end else if (step) begin
         q      <= q_step;
         wrap   <= hit;
         count  <= hit ? '0 : count + CNT_W'(1);
      end else begin
         wrap   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen at NBITS=4, CNT_W=8.
module tb_lfsr_gen;
   localparam int NBITS = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [127:0]     data;
   logic             load, mode, en, ready;
   logic [NBITS-1:0] taps;
   logic [NBITS-1:0] q;
   logic             valid, lockup, wrap;
   logic [CNT_W-1:0] count;
   logic [14:0]      obs;

   int tests = 0;
   int errs  = 0;

   logic [3:0] fib_seq [16];
   logic [3:0] gal_seq [16];

   lfsr_gen #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .data(data), .load(load), .taps(taps), .mode(mode),
      .en(en), .ready(ready), .q(q), .valid(valid), .lockup(lockup), .wrap(wrap),
      .count(count)
   );

   always #5 clk = ~clk;

   // obs = {q, valid, lockup, wrap, count}
   assign obs = {q, valid, lockup, wrap, count};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; load = 1'b0; data = '0; taps = '0; mode = 1'b0; en = 1'b0; ready = 1'b0;
      tick(); tick();
      tests++;
      if (obs !== 15'h0) begin
         errs++; $display("FAIL reset obs got %h exp %h", obs, 15'h0);
      end
      rst = 1'b1;
      tick();
      tests++;
      if (obs !== 15'h0) begin
         errs++; $display("FAIL idle_hold obs got %h exp %h", obs, 15'h0);
      end
   endtask

   task automatic test_fib();
      logic [14:0] exp;
      data = 128'h1; taps = 4'b1001; mode = 1'b0; load = 1'b1; en = 1'b1; ready = 1'b1;
      tick();
      load = 1'b0; data = 128'h7;
      exp = {4'h1, 1'b1, 1'b0, 1'b0, 8'd0};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL fib_load obs got %h exp %h", obs, exp);
      end
      for (int i = 1; i < 16; i++) begin
         tick();
         exp = (i == 15) ? {fib_seq[i], 1'b1, 1'b0, 1'b1, 8'd0}
                         : {fib_seq[i], 1'b1, 1'b0, 1'b0, 8'(i)};
         tests++;
         if (obs !== exp) begin
            errs++; $display("FAIL fib_step%0d obs got %h exp %h", i, obs, exp);
         end
      end
      tick();
      exp = {4'h3, 1'b1, 1'b0, 1'b0, 8'd1};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL fib_after_wrap obs got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_stall();
      logic [14:0] exp;
      exp = {4'h3, 1'b1, 1'b0, 1'b0, 8'd1};
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if (obs !== exp) begin
            errs++; $display("FAIL stall_ready%0d obs got %h exp %h", i, obs, exp);
         end
      end
      ready = 1'b1; en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++;
         if (obs !== exp) begin
            errs++; $display("FAIL stall_en%0d obs got %h exp %h", i, obs, exp);
         end
      end
      en = 1'b1;
      tick();
      exp = {4'h7, 1'b1, 1'b0, 1'b0, 8'd2};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL stall_resume obs got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_galois();
      logic [14:0] exp;
      data = 128'h1; taps = 4'b1100; mode = 1'b1; load = 1'b1;
      tick();
      // Changing taps/mode/data without load must not disturb the sequence.
      load = 1'b0; taps = 4'b0011; mode = 1'b0; data = 128'hA;
      exp = {4'h1, 1'b1, 1'b0, 1'b0, 8'd0};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL gal_load obs got %h exp %h", obs, exp);
      end
      for (int i = 1; i < 16; i++) begin
         tick();
         exp = (i == 15) ? {gal_seq[i], 1'b1, 1'b0, 1'b1, 8'd0}
                         : {gal_seq[i], 1'b1, 1'b0, 1'b0, 8'(i)};
         tests++;
         if (obs !== exp) begin
            errs++; $display("FAIL gal_step%0d obs got %h exp %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_lock();
      logic [14:0] exp;
      data = 128'h0; taps = 4'b1001; mode = 1'b0; load = 1'b1;
      tick();
      load = 1'b0;
      exp = {4'h0, 1'b0, 1'b1, 1'b0, 8'd0};
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (obs !== exp) begin
            errs++; $display("FAIL lock_zero%0d obs got %h exp %h", i, obs, exp);
         end
         tick();
      end
      data = 128'h5; load = 1'b1;
      tick();
      load = 1'b0;
      exp = {4'h5, 1'b1, 1'b0, 1'b0, 8'd0};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL lock_exit obs got %h exp %h", obs, exp);
      end
      tick();
      exp = {4'hB, 1'b1, 1'b0, 1'b0, 8'd1};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL lock_exit_step obs got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_zero_taps();
      logic [14:0] exp;
      data = 128'h8; taps = 4'b0000; mode = 1'b0; load = 1'b1;
      tick();
      load = 1'b0;
      exp = {4'h8, 1'b1, 1'b0, 1'b0, 8'd0};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL ztaps_load obs got %h exp %h", obs, exp);
      end
      exp = {4'h0, 1'b0, 1'b1, 1'b0, 8'd1};
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (obs !== exp) begin
            errs++; $display("FAIL ztaps_lock%0d obs got %h exp %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] exp;
      data = 128'h1; taps = 4'b1001; mode = 1'b0; load = 1'b1;
      tick();
      load = 1'b0;
      tick(); tick(); tick();
      exp = {4'hF, 1'b1, 1'b0, 1'b0, 8'd3};
      tests++;
      if (obs !== exp) begin
         errs++; $display("FAIL rmid_pre obs got %h exp %h", obs, exp);
      end
      rst = 1'b0; load = 1'b1; data = 128'h5;
      tick();
      rst = 1'b1; load = 1'b0;
      tests++;
      if (obs !== 15'h0) begin
         errs++; $display("FAIL rmid_reset obs got %h exp %h", obs, 15'h0);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++;
         if (obs !== 15'h0) begin
            errs++; $display("FAIL rmid_idle%0d obs got %h exp %h", i, obs, 15'h0);
         end
      end
   endtask

   initial begin
      fib_seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                  4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
      gal_seq = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                  4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
      test_reset();
      test_fib();
      test_stall();
      test_galois();
      test_lock();
      test_zero_taps();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
